clock_set_mode_controller: RTL and testbench

- Front-panel mode sequencer for the 7-segment clock.
- Converts two debounced buttons (MODE, INC) into:
  - a run / set-hours / set-minutes / set-seconds state,
  - single-cycle increment strobes for the time register,
  - a field-blink enable for the display.
- o_set_time drives the decimal point controller's set-time input. o_field and o_blank go to the digit blanking logic.
- Timebase is a slow one-cycle strobe from the clock divider.

---
 rtl/clock_mode_pkg.sv | 45 ++++
 rtl/button_repeat.sv | 85 ++++++++
 rtl/clock_set_mode_controller.sv | 115 +++++++++++
 tb/tb_clock_set_mode_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_mode_pkg.sv
// Shared encodings and defaults for the front-panel clock-set mode sequencer.
package clock_mode_pkg;

   // State encodings double as the field code driven on o_field.
   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StSetHrs = 2'd1,
      StSetMin = 2'd2,
      StSetSec = 2'd3
   } state_e;

   localparam logic [1:0] FieldNone = 2'd0;
   localparam logic [1:0] FieldHrs  = 2'd1;
   localparam logic [1:0] FieldMin  = 2'd2;
   localparam logic [1:0] FieldSec  = 2'd3;

   localparam int unsigned DefTickHz       = 16;
   localparam int unsigned DefHoldTicks    = 8;
   localparam int unsigned DefRepeatTicks  = 4;
   localparam int unsigned DefTimeoutTicks = 160;

   // MODE press order: RUN -> hours -> minutes -> seconds -> RUN.
   function automatic state_e next_mode(input state_e st);
      state_e nxt;
      unique case (st)
         StRun:    nxt = StSetHrs;
         StSetHrs: nxt = StSetMin;
         StSetMin: nxt = StSetSec;
         default:  nxt = StRun;
      endcase
      return nxt;
   endfunction

   function automatic logic [1:0] field_of(input state_e st);
      logic [1:0] f;
      unique case (st)
         StSetHrs: f = FieldHrs;
         StSetMin: f = FieldMin;
         StSetSec: f = FieldSec;
         default:  f = FieldNone;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/button_repeat.sv
// Button edge detect with hold-to-auto-repeat strobe generation.
// A press only counts once the button has been seen released since the last clear, so a
// button held through reset or through a clear never strobes or auto-repeats.
module button_repeat
   import clock_mode_pkg::*;
#(
   parameter int unsigned HOLD_TICKS   = DefHoldTicks,
   parameter int unsigned REPEAT_TICKS = DefRepeatTicks
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_btn,
   input  logic i_clr,
   output logic o_rise,
   output logic o_stb
);

   localparam int unsigned MaxTicks = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int unsigned CntW     = $clog2(MaxTicks + 1);
   localparam logic [CntW-1:0] HoldC   = CntW'(HOLD_TICKS);
   localparam logic [CntW-1:0] RepeatC = CntW'(REPEAT_TICKS);

   logic            btn_q;
   logic            armed_q, armed_d;
   logic            rep_q, rep_d;
   logic            stb_q, stb_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;
   logic [CntW-1:0] target;

   assign o_rise = i_btn & ~btn_q;
   assign o_stb  = stb_q;

   // Arm on release, count ticks while held, strobe on press and on each hold/repeat period.
   always_comb begin
      armed_d = armed_q;
      rep_d   = rep_q;
      cnt_d   = cnt_q;
      stb_d   = 1'b0;
      target  = rep_q ? RepeatC : HoldC;
      cnt_inc = cnt_q + 1'b1;

      if (!i_btn) begin
         armed_d = 1'b1;
      end else if (i_clr) begin
         armed_d = 1'b0;
      end

      if (i_clr || !i_btn || !armed_q) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (o_rise) begin
         stb_d = 1'b1;
         cnt_d = CntW'(i_tick);
         rep_d = 1'b0;
      end else if (i_tick) begin
         if (cnt_inc == target) begin
            stb_d = 1'b1;
            cnt_d = '0;
            rep_d = 1'b1;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Button history, hold counter and registered strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         btn_q   <= 1'b0;
         armed_q <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
         stb_q   <= 1'b0;
      end else begin
         btn_q   <= i_btn;
         armed_q <= armed_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
         stb_q   <= stb_d;
      end
   end

endmodule

// File: rtl/clock_set_mode_controller.sv
// Front-panel mode sequencer: MODE cycles run/set states, INC issues increment strobes,
// idle set states time out back to RUN, and the selected field blinks at 2 Hz.
module clock_set_mode_controller
   import clock_mode_pkg::*;
#(
   parameter int unsigned TICK_HZ       = DefTickHz,
   parameter int unsigned HOLD_TICKS    = DefHoldTicks,
   parameter int unsigned REPEAT_TICKS  = DefRepeatTicks,
   parameter int unsigned TIMEOUT_TICKS = DefTimeoutTicks
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_inc,
   output logic       o_set_time,
   output logic [1:0] o_field,
   output logic       o_inc_stb,
   output logic       o_blank
);

   localparam int unsigned MaxHr  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int unsigned MaxHt  = (MaxHr > TICK_HZ) ? MaxHr : TICK_HZ;
   localparam int unsigned MaxAll = (MaxHt > TIMEOUT_TICKS) ? MaxHt : TIMEOUT_TICKS;
   localparam int unsigned CntW   = $clog2(MaxAll + 1);
   localparam logic [CntW-1:0] TimeoutC   = CntW'(TIMEOUT_TICKS);
   localparam logic [CntW-1:0] PhaseLastC = CntW'(TICK_HZ / 2 - 1);
   localparam logic [CntW-1:0] PhaseUpC   = CntW'(TICK_HZ / 4);

   state_e          state_q, state_d;
   logic            mode_q;
   logic            mode_rise;
   logic            inc_rise;
   logic            inc_clr;
   logic [CntW-1:0] idle_q, idle_d;
   logic [CntW-1:0] phase_q, phase_d;
   logic            set_time_q, set_time_d;
   logic [1:0]      field_q, field_d;
   logic            blank_q, blank_d;

   assign mode_rise  = i_btn_mode & ~mode_q;
   assign o_set_time = set_time_q;
   assign o_field    = field_q;
   assign o_blank    = blank_q;

   // Next state: a MODE edge advances and beats a coincident timeout.
   always_comb begin
      state_d = state_q;
      if (mode_rise) begin
         state_d = next_mode(state_q);
      end else if (state_q != StRun && idle_q == TimeoutC) begin
         state_d = StRun;
      end
   end

   // INC is cleared whenever MODE moves the state or the next state is RUN.
   assign inc_clr = mode_rise | (state_d == StRun);

   button_repeat #(
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) u_inc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_tick (i_tick),
      .i_btn  (i_btn_inc),
      .i_clr  (inc_clr),
      .o_rise (inc_rise),
      .o_stb  (o_inc_stb)
   );

   // Idle timeout and blink phase counters plus decoded outputs.
   always_comb begin
      idle_d = idle_q;
      if (state_d == StRun || mode_rise || inc_rise || o_inc_stb) begin
         idle_d = '0;
      end else if (i_tick && idle_q != TimeoutC) begin
         idle_d = idle_q + 1'b1;
      end

      phase_d = phase_q;
      if (state_d == StRun || state_d != state_q) begin
         phase_d = '0;
      end else if (i_tick) begin
         phase_d = (phase_q == PhaseLastC) ? '0 : phase_q + 1'b1;
      end

      set_time_d = (state_d != StRun);
      field_d    = field_of(state_d);
      // Digits stay lit while INC is held so the user sees the value change.
      blank_d    = set_time_d & (phase_d >= PhaseUpC) & ~i_btn_inc;
   end

   // State register and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= StRun;
         mode_q     <= 1'b0;
         idle_q     <= '0;
         phase_q    <= '0;
         set_time_q <= 1'b0;
         field_q    <= FieldNone;
         blank_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= i_btn_mode;
         idle_q     <= idle_d;
         phase_q    <= phase_d;
         set_time_q <= set_time_d;
         field_q    <= field_d;
         blank_q    <= blank_d;
      end
   end

endmodule

// File: tb/tb_clock_set_mode_controller.sv
// Directed bench for clock_set_mode_controller with default parameters.
module tb_clock_set_mode_controller;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_tick;
   logic       i_btn_mode;
   logic       i_btn_inc;
   logic       o_set_time;
   logic [1:0] o_field;
   logic       o_inc_stb;
   logic       o_blank;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct packed {
      logic       tick;
      logic       mode;
      logic       inc;
      logic       set;
      logic [1:0] field;
      logic       stb;
      logic       blank;
   } vec_t;

   vec_t vecs [18];

   clock_set_mode_controller dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_tick     (i_tick),
      .i_btn_mode (i_btn_mode),
      .i_btn_inc  (i_btn_inc),
      .o_set_time (o_set_time),
      .o_field    (o_field),
      .o_inc_stb  (o_inc_stb),
      .o_blank    (o_blank)
   );

   always #5 i_clk = ~i_clk;

   function automatic vec_t mkv(input logic t, input logic m, input logic b, input logic s,
                                input logic [1:0] f, input logic st, input logic bl);
      vec_t v;
      v.tick = t; v.mode = m; v.inc = b; v.set = s; v.field = f; v.stb = st; v.blank = bl;
      return v;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Drive one cycle of inputs and sample 1 ns after the rising edge.
   task automatic cyc(input logic t, input logic m, input logic b);
      i_tick     = t;
      i_btn_mode = m;
      i_btn_inc  = b;
      @(posedge i_clk);
      #1;
   endtask

   task automatic press_mode();
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   // n tick periods (tick cycle + 3 quiet cycles), tallying strobe and blank cycles.
   task automatic ticks(input int n, input logic m, input logic b, output int stb_cnt,
                        output int blank_cnt, output logic [31:0] stb_mask);
      stb_cnt   = 0;
      blank_cnt = 0;
      stb_mask  = '0;
      for (int k = 1; k <= n; k++) begin
         cyc(1'b1, m, b);
         if (o_inc_stb && k < 32) stb_mask[k] = 1'b1;
         stb_cnt   += int'(o_inc_stb);
         blank_cnt += int'(o_blank);
         for (int j = 0; j < 3; j++) begin
            cyc(1'b0, m, b);
            stb_cnt   += int'(o_inc_stb);
            blank_cnt += int'(o_blank);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sc;
      int          bc;
      logic [31:0] sm;
      logic [31:0] exp_mask;

      // tick, mode, inc -> set, field, stb, blank
      vecs[0]  = mkv(0, 0, 0, 0, 2'd0, 0, 0);
      vecs[1]  = mkv(0, 1, 0, 1, 2'd1, 0, 0);
      vecs[2]  = mkv(0, 1, 0, 1, 2'd1, 0, 0);
      vecs[3]  = mkv(1, 0, 0, 1, 2'd1, 0, 0);
      vecs[4]  = mkv(0, 0, 1, 1, 2'd1, 1, 0);
      vecs[5]  = mkv(0, 0, 1, 1, 2'd1, 0, 0);
      vecs[6]  = mkv(0, 0, 0, 1, 2'd1, 0, 0);
      vecs[7]  = mkv(0, 1, 0, 1, 2'd2, 0, 0);
      vecs[8]  = mkv(0, 0, 0, 1, 2'd2, 0, 0);
      vecs[9]  = mkv(0, 0, 1, 1, 2'd2, 1, 0);
      vecs[10] = mkv(0, 0, 0, 1, 2'd2, 0, 0);
      vecs[11] = mkv(0, 1, 0, 1, 2'd3, 0, 0);
      vecs[12] = mkv(0, 0, 1, 1, 2'd3, 1, 0);
      vecs[13] = mkv(0, 0, 0, 1, 2'd3, 0, 0);
      vecs[14] = mkv(0, 1, 0, 0, 2'd0, 0, 0);
      vecs[15] = mkv(0, 0, 1, 0, 2'd0, 0, 0);
      vecs[16] = mkv(0, 0, 0, 0, 2'd0, 0, 0);
      vecs[17] = mkv(1, 0, 0, 0, 2'd0, 0, 0);

      i_rst = 1'b1; i_tick = 1'b0; i_btn_mode = 1'b0; i_btn_inc = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Table: reset state, MODE walk through all fields, single strobes, INC ignored in RUN.
      for (int i = 0; i < 18; i++) begin
         cyc(vecs[i].tick, vecs[i].mode, vecs[i].inc);
         chk($sformatf("vec%0d_set", i), int'(o_set_time), int'(vecs[i].set));
         chk($sformatf("vec%0d_field", i), int'(o_field), int'(vecs[i].field));
         chk($sformatf("vec%0d_stb", i), int'(o_inc_stb), int'(vecs[i].stb));
         chk($sformatf("vec%0d_blank", i), int'(o_blank), int'(vecs[i].blank));
      end

      // Hold INC 20 ticks in SET_HRS: press strobe, then ticks 8, 12, 16, 20.
      press_mode();
      cyc(1'b0, 1'b0, 1'b1);
      chk("hold_press_stb", int'(o_inc_stb), 1);
      ticks(20, 1'b0, 1'b1, sc, bc, sm);
      exp_mask = (32'd1 << 8) | (32'd1 << 12) | (32'd1 << 16) | (32'd1 << 20);
      chk("hold_repeat_cycles", sc, 4);
      chk("hold_repeat_mask", int'(sm), int'(exp_mask));
      chk("hold_blank_cycles", bc, 0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("hold_release_stb", int'(o_inc_stb), 0);

      // MODE and INC rise together: MODE wins, held INC never repeats in the new field.
      cyc(1'b0, 1'b1, 1'b1);
      chk("simul_field", int'(o_field), 2);
      chk("simul_stb", int'(o_inc_stb), 0);
      ticks(12, 1'b0, 1'b1, sc, bc, sm);
      chk("simul_hold_stb", sc, 0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("simul_repress_stb", int'(o_inc_stb), 1);
      cyc(1'b0, 1'b0, 1'b0);

      // Timeout from SET_SEC with no buttons.
      press_mode();
      chk("to_enter_field", int'(o_field), 3);
      ticks(159, 1'b0, 1'b0, sc, bc, sm);
      chk("to_159_set", int'(o_set_time), 1);
      cyc(1'b1, 1'b0, 1'b0);
      chk("to_160_edge_set", int'(o_set_time), 1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("to_160_set", int'(o_set_time), 0);
      chk("to_160_field", int'(o_field), 0);

      // INC at tick 100 pushes the timeout to tick 260.
      press_mode(); press_mode(); press_mode();
      chk("to2_enter_field", int'(o_field), 3);
      ticks(100, 1'b0, 1'b0, sc, bc, sm);
      cyc(1'b0, 1'b0, 1'b1);
      chk("to2_inc_stb", int'(o_inc_stb), 1);
      cyc(1'b0, 1'b0, 1'b0);
      ticks(159, 1'b0, 1'b0, sc, bc, sm);
      chk("to2_259_set", int'(o_set_time), 1);
      ticks(1, 1'b0, 1'b0, sc, bc, sm);
      chk("to2_260_set", int'(o_set_time), 0);

      // Blink phase in SET_HRS: 4 ticks visible, 4 ticks blanked.
      press_mode();
      chk("blink_k0", int'(o_blank), 0);
      for (int k = 1; k <= 20; k++) begin
         ticks(1, 1'b0, 1'b0, sc, bc, sm);
         chk($sformatf("blink_k%0d", k), int'(o_blank), ((k % 8) >= 4) ? 1 : 0);
      end
      cyc(1'b0, 1'b0, 1'b1);
      chk("blink_inc_visible", int'(o_blank), 0);
      chk("blink_inc_stb", int'(o_inc_stb), 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("blink_release_blank", int'(o_blank), 1);

      // INC in RUN: no strobes, never blanked.
      press_mode(); press_mode(); press_mode();
      chk("run_set", int'(o_set_time), 0);
      ticks(8, 1'b0, 1'b1, sc, bc, sm);
      chk("run_inc_stb", sc, 0);
      chk("run_inc_blank", bc, 0);
      cyc(1'b0, 1'b0, 1'b0);

      // Reset mid-operation in SET_MIN with INC held.
      press_mode(); press_mode();
      cyc(1'b0, 1'b0, 1'b1);
      chk("rst_pre_stb", int'(o_inc_stb), 1);
      chk("rst_pre_field", int'(o_field), 2);
      i_rst = 1'b1;
      #1;
      chk("rst_set", int'(o_set_time), 0);
      chk("rst_field", int'(o_field), 0);
      chk("rst_stb", int'(o_inc_stb), 0);
      chk("rst_blank", int'(o_blank), 0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b1);
      chk("rst_held_stb", int'(o_inc_stb), 0);
      cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("rst_mode_field", int'(o_field), 1);
      chk("rst_mode_stb", int'(o_inc_stb), 0);
      ticks(10, 1'b0, 1'b1, sc, bc, sm);
      chk("rst_hold_stb", sc, 0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("rst_repress_stb", int'(o_inc_stb), 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("rst_repress_width", int'(o_inc_stb), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
